// File: rtl/pcie_pkt_fetch.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module   : pcie_pkt_fetch
// Brief    : Pairs descriptors with packet flits and forwards them, tagged with
//            queue IDs and flit index, through a single output register.
// Revision : 1.0 - initial release
// ============================================================================
module pcie_pkt_fetch #(
    parameter int APP_IDX_WIDTH  = 10,
    parameter int FLOW_IDX_WIDTH = 14
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic [APP_IDX_WIDTH-1:0]  desc_dsc_queue_id,
    input  logic [FLOW_IDX_WIDTH-1:0] desc_pkt_queue_id,
    input  logic [15:0]               desc_size,
    input  logic                      desc_valid,
    output logic                      desc_ready,
    input  logic [511:0]              pkt_data,
    input  logic                      pkt_sop,
    input  logic                      pkt_eop,
    input  logic                      pkt_valid,
    output logic                      pkt_ready,
    output logic [511:0]              out_data,
    output logic                      out_sop,
    output logic                      out_eop,
    output logic                      out_valid,
    input  logic                      out_ready,
    output logic [APP_IDX_WIDTH-1:0]  out_dsc_queue_id,
    output logic [FLOW_IDX_WIDTH-1:0] out_pkt_queue_id,
    output logic [15:0]               out_flit_idx,
    output logic [31:0]               pkt_cnt,
    output logic [15:0]               err_cnt
);

    localparam logic [1:0] c_IDLE  = 2'd0;
    localparam logic [1:0] c_XFER  = 2'd1;
    localparam logic [1:0] c_DRAIN = 2'd2;

    logic [1:0]                state_q, state_d;
    logic [15:0]               remaining_q;
    logic [15:0]               flit_idx_q;
    logic [APP_IDX_WIDTH-1:0]  dsc_id_q;
    logic [FLOW_IDX_WIDTH-1:0] pkt_id_q;
    logic [511:0]              out_data_q;
    logic                      out_sop_q, out_eop_q, out_valid_q;
    logic [APP_IDX_WIDTH-1:0]  out_dsc_id_q;
    logic [FLOW_IDX_WIDTH-1:0] out_pkt_id_q;
    logic [15:0]               out_flit_idx_q;
    logic [31:0]               pkt_cnt_q;
    logic [15:0]               err_cnt_q;

    logic w_adv, w_desc_pop, w_desc_start, w_flit_pop, w_load, w_last;
    logic w_pkt_ok, w_err;
    logic w_unused;

    // Framing is derived from the descriptor size; the incoming sop is ignored.
    assign w_unused     = pkt_sop;

    assign w_adv        = !out_valid_q || out_ready;
    assign w_desc_pop   = desc_ready && desc_valid;
    assign w_desc_start = w_desc_pop && (desc_size != 16'd0);
    assign w_flit_pop   = pkt_ready && pkt_valid;
    assign w_load       = w_flit_pop && (state_q == c_XFER);
    assign w_last       = (remaining_q == 16'd1);
    assign w_pkt_ok     = w_load && pkt_eop && w_last;
    // Zero-size descriptor, early eop, or missing eop on the last expected flit.
    assign w_err        = (w_desc_pop && (desc_size == 16'd0)) ||
                          (w_load && (pkt_eop != w_last));

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= c_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            c_IDLE: begin
                if (w_desc_start) state_d = c_XFER;
            end
            c_XFER: begin
                if (w_load) begin
                    if (pkt_eop)     state_d = c_IDLE;
                    else if (w_last) state_d = c_DRAIN;
                end
            end
            c_DRAIN: begin
                if (w_flit_pop && pkt_eop) state_d = c_IDLE;
            end
            default: state_d = c_IDLE;
        endcase
    end

    // Pops are suppressed during reset so an abandoned packet loses no more flits.
    always_comb begin
        desc_ready = 1'b0;
        pkt_ready  = 1'b0;
        if (!rst) begin
            case (state_q)
                c_IDLE:  desc_ready = desc_valid;
                c_XFER:  pkt_ready  = w_adv;
                c_DRAIN: pkt_ready  = 1'b1;
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            remaining_q <= 16'd0;
            flit_idx_q  <= 16'd0;
            out_valid_q <= 1'b0;
            out_sop_q   <= 1'b0;
            out_eop_q   <= 1'b0;
            pkt_cnt_q   <= 32'd0;
            err_cnt_q   <= 16'd0;
        end else begin
            if (w_desc_start) begin
                remaining_q <= desc_size;
                flit_idx_q  <= 16'd0;
            end else if (w_load) begin
                remaining_q <= remaining_q - 16'd1;
                flit_idx_q  <= flit_idx_q + 16'd1;
            end
            if (w_load) begin
                out_valid_q <= 1'b1;
                out_sop_q   <= (flit_idx_q == 16'd0);
                out_eop_q   <= pkt_eop || w_last;
            end else if (out_ready) begin
                out_valid_q <= 1'b0;
            end
            if (w_pkt_ok) begin
                pkt_cnt_q <= pkt_cnt_q + 32'd1;
            end
            if (w_err && (err_cnt_q != 16'hFFFF)) begin
                err_cnt_q <= err_cnt_q + 16'd1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (w_desc_start) begin
            dsc_id_q <= desc_dsc_queue_id;
            pkt_id_q <= desc_pkt_queue_id;
        end
        if (w_load) begin
            out_data_q     <= pkt_data;
            out_dsc_id_q   <= dsc_id_q;
            out_pkt_id_q   <= pkt_id_q;
            out_flit_idx_q <= flit_idx_q;
        end
    end

    assign out_data         = out_data_q;
    assign out_sop          = out_sop_q;
    assign out_eop          = out_eop_q;
    assign out_valid        = out_valid_q;
    assign out_dsc_queue_id = out_dsc_id_q;
    assign out_pkt_queue_id = out_pkt_id_q;
    assign out_flit_idx     = out_flit_idx_q;
    assign pkt_cnt          = pkt_cnt_q;
    assign err_cnt          = err_cnt_q;

endmodule
`default_nettype wire

// File: tb/tb_pcie_pkt_fetch.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module   : tb_pcie_pkt_fetch
// Brief    : Self-checking bench for pcie_pkt_fetch: packet-level vector table,
//            corner-case sequences and randomized traffic against a model.
// Revision : 1.0 - initial release
// ============================================================================
module tb_pcie_pkt_fetch;
    localparam int AW = 10;
    localparam int FW = 14;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic          rst;
    logic [AW-1:0] desc_dsc_queue_id;
    logic [FW-1:0] desc_pkt_queue_id;
    logic [15:0]   desc_size;
    logic          desc_valid, desc_ready;
    logic [511:0]  pkt_data;
    logic          pkt_sop, pkt_eop, pkt_valid, pkt_ready;
    logic [511:0]  out_data;
    logic          out_sop, out_eop, out_valid, out_ready;
    logic [AW-1:0] out_dsc_queue_id;
    logic [FW-1:0] out_pkt_queue_id;
    logic [15:0]   out_flit_idx;
    logic [31:0]   pkt_cnt;
    logic [15:0]   err_cnt;

    pcie_pkt_fetch #(.APP_IDX_WIDTH(AW), .FLOW_IDX_WIDTH(FW)) dut (
        .clk(clk), .rst(rst),
        .desc_dsc_queue_id(desc_dsc_queue_id), .desc_pkt_queue_id(desc_pkt_queue_id),
        .desc_size(desc_size), .desc_valid(desc_valid), .desc_ready(desc_ready),
        .pkt_data(pkt_data), .pkt_sop(pkt_sop), .pkt_eop(pkt_eop),
        .pkt_valid(pkt_valid), .pkt_ready(pkt_ready),
        .out_data(out_data), .out_sop(out_sop), .out_eop(out_eop),
        .out_valid(out_valid), .out_ready(out_ready),
        .out_dsc_queue_id(out_dsc_queue_id), .out_pkt_queue_id(out_pkt_queue_id),
        .out_flit_idx(out_flit_idx), .pkt_cnt(pkt_cnt), .err_cnt(err_cnt)
    );

    typedef struct { logic [AW-1:0] dsc; logic [FW-1:0] pkt; logic [15:0] size; } desc_t;
    typedef struct { logic [511:0] data; logic sop; logic eop; } flit_t;
    typedef struct { logic [511:0] data; logic sop; logic eop; logic [AW-1:0] dsc;
                     logic [FW-1:0] pkt; logic [15:0] idx; int cyc; } out_t;
    typedef struct { logic [AW-1:0] dsc; logic [FW-1:0] pkt; logic [15:0] size; int nflits;
                     bit toggle; int nout; int eop_idx; int npkt; int nerr; } vec_t;

    desc_t dq[$], gen_d[$];
    flit_t fq[$], gen_f[$];
    out_t  got[$], exp_q[$];
    logic [511:0] vdata[$];

    int checks = 0, errors = 0;
    int cyc = 0;
    int or_mode = 0;
    bit rnd_gate = 0;
    bit hold_chk = 0;
    out_t hold_snap;
    bit saw_pkt_ready;
    int desc_pop_cyc, first_pkt_pop_cyc, first_ov_cyc;
    int exp_pkt_tot = 0, exp_err_tot = 0;
    logic s_ov, s_sop, s_eop, s_dr, s_pr;
    logic [31:0] s_pc;
    logic [15:0] s_ec;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    task automatic chk_data(input string nm, input logic [511:0] act, input logic [511:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got ..%h expected ..%h", nm, act[63:0], exp[63:0]);
        end
    endtask

    function automatic logic [511:0] rnd512();
        logic [511:0] r;
        for (int i = 0; i < 16; i++) r[i*32 +: 32] = $urandom;
        return r;
    endfunction

    function automatic out_t cur_out();
        out_t o;
        o = '{out_data, out_sop, out_eop, out_dsc_queue_id, out_pkt_queue_id, out_flit_idx, cyc};
        return o;
    endfunction

    // One clock: present FIFO heads, sample at negedge, retire handshakes.
    task automatic step();
        out_t c;
        if (dq.size() > 0 && (!rnd_gate || $urandom_range(0, 3) != 0)) begin
            desc_valid = 1'b1; desc_dsc_queue_id = dq[0].dsc;
            desc_pkt_queue_id = dq[0].pkt; desc_size = dq[0].size;
        end else begin
            desc_valid = 1'b0; desc_dsc_queue_id = '0; desc_pkt_queue_id = '0; desc_size = '0;
        end
        if (fq.size() > 0 && (!rnd_gate || $urandom_range(0, 3) != 0)) begin
            pkt_valid = 1'b1; pkt_data = fq[0].data; pkt_sop = fq[0].sop; pkt_eop = fq[0].eop;
        end else begin
            pkt_valid = 1'b0; pkt_data = '0; pkt_sop = 1'b0; pkt_eop = 1'b0;
        end
        case (or_mode)
            0:       out_ready = 1'b1;
            1:       out_ready = cyc[0];
            default: out_ready = 1'($urandom_range(0, 1));
        endcase
        @(negedge clk);
        s_ov = out_valid; s_sop = out_sop; s_eop = out_eop; s_dr = desc_ready;
        s_pr = pkt_ready; s_pc = pkt_cnt; s_ec = err_cnt;
        c = cur_out();
        if (hold_chk) begin
            checks++;
            if (!out_valid || c.data !== hold_snap.data || c.sop !== hold_snap.sop ||
                c.eop !== hold_snap.eop || c.dsc !== hold_snap.dsc ||
                c.pkt !== hold_snap.pkt || c.idx !== hold_snap.idx) begin
                errors++;
                $display("FAIL hold: out changed while stalled, idx %0h->%0h valid %0b",
                         hold_snap.idx, c.idx, out_valid);
            end
        end
        hold_chk  = out_valid && !out_ready && !rst;
        hold_snap = c;
        if (pkt_ready) saw_pkt_ready = 1'b1;
        if (desc_valid && desc_ready) begin
            void'(dq.pop_front());
            desc_pop_cyc = cyc;
        end
        if (pkt_valid && pkt_ready) begin
            void'(fq.pop_front());
            if (first_pkt_pop_cyc < 0) first_pkt_pop_cyc = cyc;
        end
        if (out_valid && first_ov_cyc < 0) first_ov_cyc = cyc;
        if (out_valid && out_ready) got.push_back(c);
        @(posedge clk);
        #1;
        cyc++;
    endtask

    task automatic run_until_done();
        int quiet = 0;
        int n = 0;
        while (quiet < 2) begin
            step();
            if (dq.size() == 0 && fq.size() == 0 && !s_ov) quiet++;
            else quiet = 0;
            n++;
            if (n > 3000) begin
                chk("run_timeout", 64'(n), 64'd3000);
                rst = 1'b1; dq.delete(); fq.delete();
                step();
                rst = 1'b0;
                exp_pkt_tot = 0; exp_err_tot = 0;
                quiet = 2;
            end
        end
    endtask

    // Reference: walk descriptors and the flit stream at packet level.
    task automatic model();
        int fi;
        int k;
        bit done;
        flit_t f;
        out_t o;
        fi = 0;
        exp_q.delete();
        foreach (gen_d[d]) begin
            if (gen_d[d].size == 0) begin
                exp_err_tot++;
                continue;
            end
            k = 0;
            done = 0;
            while (!done && fi < gen_f.size()) begin
                f = gen_f[fi];
                fi++;
                if (k < int'(gen_d[d].size)) begin
                    o = '{f.data, 1'(k == 0), f.eop || (k == int'(gen_d[d].size) - 1),
                          gen_d[d].dsc, gen_d[d].pkt, 16'(k), 0};
                    exp_q.push_back(o);
                end
                if (f.eop) begin
                    done = 1;
                    if (k == int'(gen_d[d].size) - 1) exp_pkt_tot++;
                    else if (k < int'(gen_d[d].size) - 1) exp_err_tot++;
                end else if (k == int'(gen_d[d].size) - 1) begin
                    exp_err_tot++;
                end
                k++;
            end
        end
    endtask

    vec_t vt[7];

    initial begin
        vt[0] = '{3,    7,     4, 4, 0, 4,  3, 1, 0};
        vt[1] = '{3,    7,     4, 4, 1, 4,  3, 1, 0};
        vt[2] = '{5,    9,     3, 2, 0, 2,  1, 0, 1};
        vt[3] = '{1,    2,     1, 1, 0, 1,  0, 1, 0};
        vt[4] = '{8,    4,     2, 5, 0, 2,  1, 0, 1};
        vt[5] = '{0,    0,     0, 0, 0, 0, -1, 0, 1};
        vt[6] = '{1023, 16383, 1, 3, 1, 1,  0, 0, 1};

        rst = 1'b1;
        desc_valid = 0; desc_dsc_queue_id = '0; desc_pkt_queue_id = '0; desc_size = '0;
        pkt_valid = 0; pkt_data = '0; pkt_sop = 0; pkt_eop = 0; out_ready = 1'b1;
        @(posedge clk);
        #1;
        for (int i = 0; i < 3; i++) step();
        rst = 1'b0;
        step();
        chk("rst_out_valid", 64'(s_ov), 64'd0);
        chk("rst_out_sop", 64'(s_sop), 64'd0);
        chk("rst_out_eop", 64'(s_eop), 64'd0);
        chk("rst_desc_ready", 64'(s_dr), 64'd0);
        chk("rst_pkt_ready", 64'(s_pr), 64'd0);
        chk("rst_pkt_cnt", 64'(s_pc), 64'd0);
        chk("rst_err_cnt", 64'(s_ec), 64'd0);

        for (int v = 0; v < 7; v++) begin
            logic [31:0] w;
            dq.push_back('{vt[v].dsc, vt[v].pkt, vt[v].size});
            vdata.delete();
            for (int i = 0; i < vt[v].nflits; i++) begin
                w = 32'hA5A5_0000 + 32'(v * 256 + i);
                vdata.push_back({16{w}});
                fq.push_back('{{16{w}}, 1'(i == 0), 1'(i == vt[v].nflits - 1)});
            end
            got.delete();
            saw_pkt_ready = 0;
            or_mode = vt[v].toggle ? 1 : 0;
            rnd_gate = 0;
            run_until_done();
            chk($sformatf("v%0d_nout", v), 64'(got.size()), 64'(vt[v].nout));
            for (int i = 0; i < got.size() && i < vt[v].nout; i++) begin
                chk($sformatf("v%0d_idx%0d", v, i), 64'(got[i].idx), 64'(i));
                chk($sformatf("v%0d_sop%0d", v, i), 64'(got[i].sop), 64'(i == 0));
                chk($sformatf("v%0d_eop%0d", v, i), 64'(got[i].eop), 64'(i == vt[v].eop_idx));
                chk($sformatf("v%0d_dsc%0d", v, i), 64'(got[i].dsc), 64'(vt[v].dsc));
                chk($sformatf("v%0d_pkt%0d", v, i), 64'(got[i].pkt), 64'(vt[v].pkt));
                chk_data($sformatf("v%0d_data%0d", v, i), got[i].data, vdata[i]);
                if (!vt[v].toggle && i > 0)
                    chk($sformatf("v%0d_tput%0d", v, i), 64'(got[i].cyc), 64'(got[0].cyc + i));
            end
            exp_pkt_tot += vt[v].npkt;
            exp_err_tot += vt[v].nerr;
            chk($sformatf("v%0d_pkt_cnt", v), 64'(pkt_cnt), 64'(exp_pkt_tot));
            chk($sformatf("v%0d_err_cnt", v), 64'(err_cnt), 64'(exp_err_tot));
            if (vt[v].size == 16'd0)
                chk($sformatf("v%0d_no_pkt_ready", v), 64'(saw_pkt_ready), 64'd0);
        end

        // Descriptor-to-first-flit latency.
        desc_pop_cyc = -1; first_pkt_pop_cyc = -1; first_ov_cyc = -1;
        dq.push_back('{10'd4, 14'd4, 16'd2});
        fq.push_back('{rnd512(), 1'b1, 1'b0});
        fq.push_back('{rnd512(), 1'b0, 1'b1});
        got.delete();
        or_mode = 0;
        run_until_done();
        exp_pkt_tot++;
        chk("lat_first_pop", 64'(first_pkt_pop_cyc), 64'(desc_pop_cyc + 1));
        chk("lat_first_out", 64'(first_ov_cyc), 64'(desc_pop_cyc + 2));
        chk("lat_pkt_cnt", 64'(pkt_cnt), 64'(exp_pkt_tot));

        // Reset after the second flit of a 4-flit packet.
        dq.push_back('{10'd2, 14'd5, 16'd4});
        for (int i = 0; i < 4; i++) fq.push_back('{rnd512(), 1'(i == 0), 1'(i == 3)});
        for (int n = 0; n < 50 && fq.size() > 2; n++) step();
        chk("mid_pops", 64'(fq.size()), 64'd2);
        rst = 1'b1;
        dq.delete();
        fq.delete();
        step();
        rst = 1'b0;
        step();
        exp_pkt_tot = 0;
        exp_err_tot = 0;
        chk("mid_rst_out_valid", 64'(s_ov), 64'd0);
        chk("mid_rst_sop_eop", 64'({s_sop, s_eop}), 64'd0);
        chk("mid_rst_readies", 64'({s_dr, s_pr}), 64'd0);
        chk("mid_rst_cnts", 64'({s_pc, s_ec}), 64'd0);
        dq.push_back('{10'd6, 14'd11, 16'd1});
        fq.push_back('{{16{32'h0BAD_F00D}}, 1'b1, 1'b1});
        got.delete();
        run_until_done();
        chk("post_rst_nout", 64'(got.size()), 64'd1);
        if (got.size() > 0) begin
            chk("post_rst_sop_eop", 64'({got[0].sop, got[0].eop}), 64'd3);
            chk("post_rst_ids", 64'({got[0].dsc, got[0].pkt}), 64'({10'd6, 14'd11}));
        end
        chk("post_rst_pkt_cnt", 64'(pkt_cnt), 64'd1);
        exp_pkt_tot = 1;

        // Randomized traffic against the packet-level model.
        for (int it = 0; it < 30; it++) begin
            int nd;
            int sz;
            int len;
            gen_d.delete();
            gen_f.delete();
            nd = $urandom_range(1, 3);
            for (int d = 0; d < nd; d++) begin
                sz = ($urandom_range(0, 7) == 0) ? 0 : $urandom_range(1, 5);
                gen_d.push_back('{10'($urandom), 14'($urandom), 16'(sz)});
                if (sz != 0) begin
                    len = ($urandom_range(0, 1) == 0) ? sz : $urandom_range(1, 6);
                    for (int i = 0; i < len; i++)
                        gen_f.push_back('{rnd512(), 1'(i == 0), 1'(i == len - 1)});
                end
            end
            model();
            foreach (gen_d[i]) dq.push_back(gen_d[i]);
            foreach (gen_f[i]) fq.push_back(gen_f[i]);
            got.delete();
            or_mode = 2;
            rnd_gate = 1;
            run_until_done();
            chk($sformatf("r%0d_nout", it), 64'(got.size()), 64'(exp_q.size()));
            for (int i = 0; i < got.size() && i < exp_q.size(); i++) begin
                chk($sformatf("r%0d_hdr%0d", it, i),
                    64'({got[i].sop, got[i].eop, got[i].dsc, got[i].pkt, got[i].idx}),
                    64'({exp_q[i].sop, exp_q[i].eop, exp_q[i].dsc, exp_q[i].pkt, exp_q[i].idx}));
                chk_data($sformatf("r%0d_data%0d", it, i), got[i].data, exp_q[i].data);
            end
            chk($sformatf("r%0d_pkt_cnt", it), 64'(pkt_cnt), 64'(exp_pkt_tot));
            chk($sformatf("r%0d_err_cnt", it), 64'(err_cnt), 64'(exp_err_tot));
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
`default_nettype wire

// File: doc/pcie_pkt_fetch.md
PCIE_PKT_FETCH -- requirements
Module: pcie_pkt_fetch

Interface
REQ-001 SHALL have parameter APP_IDX_WIDTH, default 10, width of the descriptor-queue ID.
REQ-002 SHALL have parameter FLOW_IDX_WIDTH, default 14, width of the packet-queue ID.
REQ-003 clk  in  1  single clock; every register samples on its rising edge.
REQ-004 rst  in  1  synchronous, active-high reset.
REQ-005 desc_dsc_queue_id  in  APP_IDX_WIDTH  descriptor field, from the show-ahead descriptor FIFO.
REQ-006 desc_pkt_queue_id  in  FLOW_IDX_WIDTH  descriptor field.
REQ-007 desc_size  in  16  packet length in 64-byte flits.
REQ-008 desc_valid  in  1  descriptor FIFO not empty.
REQ-009 desc_ready  out  1  pops one descriptor in the cycle it is high.
REQ-010 pkt_data  in  512  flit from the show-ahead packet FIFO.
REQ-011 pkt_sop, pkt_eop  in  1 each  flit framing.
REQ-012 pkt_valid  in  1  packet FIFO not empty.
REQ-013 pkt_ready  out  1  pops one flit in the cycle it is high.
REQ-014 out_data  out  512  flit to the DMA engine.
REQ-015 out_sop, out_eop  out  1 each  flit framing.
REQ-016 out_valid  out  1  output flit valid.
REQ-017 out_ready  in  1  DMA engine accepts the flit.
REQ-018 out_dsc_queue_id, out_pkt_queue_id  out  APP_IDX_WIDTH / FLOW_IDX_WIDTH  queue IDs of the current packet, held for every flit.
REQ-019 out_flit_idx  out  16  zero-based flit index within the packet.
REQ-020 pkt_cnt  out  32  count of well-formed packets forwarded; wraps.
REQ-021 err_cnt  out  16  count of framing errors; saturates at 0xFFFF.

Function
REQ-022 SHALL implement a state machine with states IDLE, XFER and DRAIN.
REQ-023 Output stage SHALL be a single register; a flit transfers on out_valid && out_ready.
REQ-024 The output register SHALL be able to accept a new flit when "adv" = !out_valid || out_ready.
REQ-025 IDLE with desc_valid and desc_size != 0: SHALL latch the IDs, set remaining = desc_size, set flit index = 0, pulse desc_ready for 1 cycle, and enter XFER.
REQ-026 IDLE with desc_valid and desc_size == 0: SHALL pulse desc_ready, increment err_cnt, and stay in IDLE.
REQ-027 desc_ready SHALL be low in all states other than IDLE.
REQ-028 XFER: pkt_ready = adv. When pkt_valid && adv, SHALL load the output register with pkt_data and the latched IDs, and set out_valid = 1.
REQ-029 XFER loads: out_sop = (flit index == 0), regardless of pkt_sop.
REQ-030 XFER loads: decrement remaining and increment flit index.
REQ-031 XFER, remaining == 1 and pkt_eop: SHALL set out_eop = 1, increment pkt_cnt, and go to IDLE.
REQ-032 XFER, remaining > 1 and pkt_eop (short packet): SHALL force out_eop = 1, increment err_cnt, and go to IDLE.
REQ-033 XFER, remaining == 1 and !pkt_eop (long packet): SHALL set out_eop = 1, increment err_cnt, and go to DRAIN.
REQ-034 DRAIN: pkt_ready = 1 and out_valid is not loaded; leave DRAIN for IDLE after popping a flit with pkt_eop.
REQ-035 When out_ready is high and no new flit is loaded, out_valid SHALL clear.
REQ-036 While out_valid && !out_ready, all out_* SHALL hold stable.
REQ-037 Latency: a flit popped in cycle N SHALL appear on out_* in cycle N+1.
REQ-038 Throughput: one flit per cycle sustained when pkt_valid and out_ready are high.
REQ-039 Descriptor-to-first-flit latency: a descriptor accepted in IDLE at cycle N allows a flit pop at N+1; the first flit appears at N+2.
REQ-040 When one cycle has both an err_cnt and a pkt_cnt condition, each counter SHALL update independently.

Reset
REQ-041 Reset SHALL set: state = IDLE; out_valid, out_sop, out_eop = 0; desc_ready, pkt_ready = 0; pkt_cnt, err_cnt, remaining, flit index = 0.
REQ-042 out_data and the out IDs SHALL be don't-care after reset.
REQ-043 Reset asserted mid-packet SHALL abandon the packet without popping further; the next packet starts from IDLE.

Verification
REQ-044 Descriptor (dsc 3, pkt 7, size 4) plus 4 flits (eop on the 4th), out_ready = 1: 4 consecutive out flits with idx 0..3, sop on idx 0, eop on idx 3, IDs 3/7; pkt_cnt = 1.
REQ-045 Same stimulus with out_ready toggling 1/0 each cycle: identical flit sequence; data stable while stalled; no flit lost or duplicated.
REQ-046 Size 3 with eop on the 2nd flit: 2 out flits, eop on the 2nd; err_cnt = 1; the next descriptor is processed normally.
REQ-047 Size 2 with eop on the 5th flit: 2 out flits, eop forced on the 2nd; flits 3-5 popped without output; err_cnt = 1; returns to IDLE.
REQ-048 Descriptor size 0: popped in 1 cycle; no pkt_ready; err_cnt = 1.
REQ-049 Reset pulsed after the 2nd flit of a 4-flit packet: all outputs at their reset values the next cycle; a fresh 1-flit packet then forwards with sop = eop = 1.
